// File: rtl/iccm_boot_pkg.sv
// Shared types and constants for the ICCM boot loader.
// Contents: the frame parser state enum, the default frame start marker,
// field widths for COUNT and CSUM, and a helper that returns the number of
// bytes used to carry the ADDR field for a given address width.
package iccm_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4
    } boot_state_e;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
    localparam int COUNT_W = 16;
    localparam int CSUM_W  = 8;

    // Number of whole bytes needed to carry an address of width aw.
    function automatic int addr_bytes(input int aw);
        return (aw + 7) / 8;
    endfunction

endpackage

// File: rtl/iccm_boot_packer.sv
// Byte-to-word packer for the ICCM boot loader.
// Bytes arrive LSB first and are dropped into the word at the current byte
// index. When the final byte of a word lands, word_done pulses for one cycle
// with the complete word on 'word'.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   clear         - synchronous restart of the byte index (outside DATA)
//   byte_valid    - byte_in is a data byte to be packed
//   byte_in       - data byte
//   word          - registered assembled word
//   word_done     - registered one-cycle pulse: word is complete
//   last_byte     - combinational: the byte being accepted completes a word
module iccm_boot_packer #(
    parameter int DataWidth = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_in,
    output logic [DataWidth-1:0] word,
    output logic                 word_done,
    output logic                 last_byte
);

    localparam int NB = DataWidth / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0] idx_r;

    assign last_byte = byte_valid && (idx_r == IW'(NB - 1));

    // Byte index, word assembly and completion pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_r     <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= last_byte;
            if (clear) begin
                idx_r <= '0;
            end else if (byte_valid) begin
                word[{idx_r, 3'b000} +: 8] <= byte_in;
                idx_r <= last_byte ? '0 : idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: rtl/iccm_boot_loader.sv
// ICCM boot loader: parses framed, checksummed load/boot commands from a UART
// byte stream, streams words into the ICCM write port and holds the core in
// reset until a good boot frame (COUNT == 0) arrives.
// Frame: SYNC, ADDR (AB bytes), COUNT (2 bytes), DATA, CSUM; all LSB first.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   rx_dv_i        - one-cycle strobe: rx_byte_i valid
//   rx_byte_i      - received byte
//   we_o           - ICCM write strobe, one cycle per word
//   addr_o         - ICCM word address
//   wdata_o        - ICCM write data
//   core_reset_o   - high holds the core in reset
//   boot_addr_o    - word address of the last good boot frame
//   busy_o         - a frame is in progress
//   err_o          - sticky checksum/timeout error, cleared by next SYNC
module iccm_boot_loader
    import iccm_boot_pkg::*;
#(
    parameter int         AddrWidth     = 12,
    parameter int         DataWidth     = 32,
    parameter int         TimeoutCycles = 1000000,
    parameter logic [7:0] SyncByte      = DEFAULT_SYNC
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_byte_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 core_reset_o,
    output logic [AddrWidth-1:0] boot_addr_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int AB = addr_bytes(AddrWidth);
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    boot_state_e          state_r;
    logic [7:0]           byte_cnt_r;
    logic [AddrWidth-1:0] addr_acc_r;
    logic [AddrWidth-1:0] addr_next_s;
    logic [7:0]           count_lo_r;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   words_left_r;
    logic [COUNT_W-1:0]   count_next_s;
    logic [CSUM_W-1:0]    csum_r;
    logic [CSUM_W-1:0]    sum_s;
    logic [TW-1:0]        tmo_r;
    logic                 data_valid_s;
    logic                 pack_clear_s;
    logic                 last_byte_s;
    logic                 word_done_s;
    logic [DataWidth-1:0] word_s;

    assign sum_s        = csum_r + rx_byte_i;
    assign count_next_s = {rx_byte_i, count_lo_r};
    assign data_valid_s = rx_dv_i && (state_r == ST_DATA);
    assign pack_clear_s = (state_r != ST_DATA);

    // Overlay the incoming ADDR byte at its position; bits beyond AddrWidth
    // only contribute to the checksum and are never stored.
    always_comb begin
        addr_next_s = addr_acc_r;
        for (int i = 0; i < AddrWidth; i++) begin
            if ((i / 8) == int'(byte_cnt_r)) begin
                addr_next_s[i] = rx_byte_i[i % 8];
            end else begin
                addr_next_s[i] = addr_acc_r[i];
            end
        end
    end

    iccm_boot_packer #(
        .DataWidth (DataWidth)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pack_clear_s),
        .byte_valid (data_valid_s),
        .byte_in    (rx_byte_i),
        .word       (word_s),
        .word_done  (word_done_s),
        .last_byte  (last_byte_s)
    );

    // The packer's registered word/pulse are the ICCM write port directly.
    assign we_o    = word_done_s;
    assign wdata_o = word_s;

    // Frame parser FSM with address counter, checksum and inter-byte timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= 8'd0;
            addr_acc_r   <= '0;
            count_lo_r   <= 8'd0;
            count_r      <= '0;
            words_left_r <= '0;
            csum_r       <= '0;
            tmo_r        <= '0;
            addr_o       <= '0;
            core_reset_o <= 1'b1;
            boot_addr_o  <= '0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // Each written word advances the address, wrapping naturally.
            if (word_done_s) begin
                addr_o <= addr_o + AddrWidth'(1);
            end else begin
                addr_o <= addr_o;
            end

            if (state_r == ST_IDLE) begin
                tmo_r <= '0;
                if (rx_dv_i && (rx_byte_i == SyncByte)) begin
                    state_r      <= ST_ADDR;
                    busy_o       <= 1'b1;
                    err_o        <= 1'b0;
                    core_reset_o <= 1'b1;
                    csum_r       <= '0;
                    byte_cnt_r   <= 8'd0;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else if (rx_dv_i) begin
                // A strobe always beats a coincident timeout expiry.
                tmo_r <= '0;
                case (state_r)
                    ST_ADDR: begin
                        csum_r     <= sum_s;
                        addr_acc_r <= addr_next_s;
                        if (byte_cnt_r == 8'(AB - 1)) begin
                            byte_cnt_r <= 8'd0;
                            state_r    <= ST_COUNT;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 8'd1;
                        end
                    end
                    ST_COUNT: begin
                        csum_r <= sum_s;
                        if (byte_cnt_r == 8'd0) begin
                            count_lo_r <= rx_byte_i;
                            byte_cnt_r <= 8'd1;
                        end else begin
                            count_r      <= count_next_s;
                            words_left_r <= count_next_s;
                            addr_o       <= addr_acc_r;
                            byte_cnt_r   <= 8'd0;
                            state_r      <= (count_next_s == COUNT_W'(0)) ? ST_CSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        csum_r <= sum_s;
                        if (last_byte_s) begin
                            words_left_r <= words_left_r - COUNT_W'(1);
                            if (words_left_r == COUNT_W'(1)) begin
                                state_r <= ST_CSUM;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end else begin
                            words_left_r <= words_left_r;
                        end
                    end
                    ST_CSUM: begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                        if (sum_s == CSUM_W'(0)) begin
                            if (count_r == COUNT_W'(0)) begin
                                core_reset_o <= 1'b0;
                                boot_addr_o  <= addr_acc_r;
                            end else begin
                                core_reset_o <= core_reset_o;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end else if (tmo_r == TW'(TimeoutCycles - 1)) begin
                // Inter-byte silence too long: abort, flag, keep core held.
                state_r <= ST_IDLE;
                busy_o  <= 1'b0;
                err_o   <= 1'b1;
                tmo_r   <= '0;
            end else begin
                tmo_r <= tmo_r + TW'(1);
            end
        end
    end

endmodule
